// File: rtl/stego_seq_pkg.sv
// stego_seq_pkg: state encoding and error codes shared by the job sequencer
package stego_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_CLR    = 3'd2,
    S_LAUNCH = 3'd3,
    S_RUN    = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;
  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_ZERO_COVER = 3'd1;
  localparam logic [2:0] ERR_MSG_SIZE   = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd3;
  localparam logic [2:0] ERR_ABORT      = 3'd4;
endpackage

// File: rtl/seq_timeout_cnt.sv
// seq_timeout_cnt: clearable saturating cycle counter flagging when it sits at LIMIT
module seq_timeout_cnt #(
  parameter int W = 32,
  parameter logic [W-1:0] LIMIT = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
  assign tc_o = cnt_q == LIMIT;
endmodule

// File: rtl/stego_job_seq.sv
// stego_job_seq: validates a stego job, re-arms and launches the BRAM controllers, reports status
module stego_job_seq
  import stego_seq_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int CLR_CYCLES = 2,
  parameter logic [REG_WIDTH-1:0] TIMEOUT_CYCLES = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [REG_WIDTH-1:0] cover_size,
  input  logic [REG_WIDTH-1:0] msg_size,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2:0]           err_code,
  output logic                 irq,
  output logic                 sub_rst_n,
  output logic                 rd_cov_start,
  output logic                 rd_msg_start,
  output logic                 wr_start,
  output logic [REG_WIDTH-1:0] rd_cov_size,
  output logic [REG_WIDTH-1:0] rd_msg_size,
  output logic [REG_WIDTH-1:0] wr_size,
  input  logic                 rd_cov_finish,
  input  logic                 rd_msg_finish,
  input  logic                 wr_finish
);
  localparam logic [REG_WIDTH-1:0] CLR_LIM = REG_WIDTH'(CLR_CYCLES - 1);
  localparam logic [REG_WIDTH-1:0] TO_LIM = TIMEOUT_CYCLES - 1'b1;
  state_e state_q, state_d;
  logic [REG_WIDTH-1:0] cov_q, cov_d, msg_q, msg_d;
  logic [2:0] code_q, code_d, fin_q, fin_d, fin_now;
  logic busy_q, done_q, err_q, irq_q, sub_q, go_q;
  logic clr_tc, to_tc, to_hit, job_active;
  seq_timeout_cnt #(.W(REG_WIDTH), .LIMIT(CLR_LIM)) u_clr_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(state_q != S_CLR), .en_i(state_q == S_CLR), .tc_o(clr_tc)
  );
  seq_timeout_cnt #(.W(REG_WIDTH), .LIMIT(TO_LIM)) u_to_cnt (
    .clk(clk), .rst_n(rst_n), .clr_i(state_q == S_LAUNCH), .en_i(state_q == S_RUN), .tc_o(to_tc)
  );
  // counter sits at TIMEOUT_CYCLES-1 during the TIMEOUT_CYCLES-th RUN cycle
  assign to_hit = TIMEOUT_CYCLES != '0 && to_tc;
  assign fin_now = fin_q | {rd_cov_finish, rd_msg_finish, wr_finish};
  assign job_active = state_q inside {S_CHECK, S_CLR, S_LAUNCH, S_RUN};
  always_comb begin
    state_d = state_q;
    cov_d = cov_q;
    msg_d = msg_q;
    code_d = code_q;
    fin_d = fin_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CHECK;
        cov_d = cover_size;
        msg_d = msg_size;
        code_d = ERR_NONE;
      end
      S_CHECK: begin
        state_d = S_CLR;
        if (cov_q == '0) begin
          state_d = S_ERROR;
          code_d = ERR_ZERO_COVER;
        end else if ({msg_q, 3'b000} > {3'b000, cov_q}) begin
          state_d = S_ERROR;
          code_d = ERR_MSG_SIZE;
        end
      end
      S_CLR: state_d = clr_tc ? S_LAUNCH : S_CLR;
      S_LAUNCH: begin
        state_d = S_RUN;
        fin_d = '0;
      end
      S_RUN: begin
        fin_d = fin_now;
        if (&fin_now) state_d = S_DONE;
        else if (to_hit) begin
          state_d = S_ERROR;
          code_d = ERR_TIMEOUT;
        end
      end
      S_DONE, S_ERROR: state_d = start ? state_q : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && job_active) begin
      state_d = S_ERROR;
      code_d = ERR_ABORT;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cov_q <= '0;
      msg_q <= '0;
      code_q <= ERR_NONE;
      fin_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      irq_q <= 1'b0;
      sub_q <= 1'b0;
      go_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cov_q <= cov_d;
      msg_q <= msg_d;
      code_q <= code_d;
      fin_q <= fin_d;
      busy_q <= state_d inside {S_CHECK, S_CLR, S_LAUNCH, S_RUN};
      done_q <= state_d == S_DONE;
      err_q <= state_d == S_ERROR;
      irq_q <= (state_d == S_DONE || state_d == S_ERROR) && state_d != state_q;
      sub_q <= state_d inside {S_LAUNCH, S_RUN, S_DONE};
      go_q <= state_d inside {S_LAUNCH, S_RUN};
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
  assign err_code = code_q;
  assign irq = irq_q;
  assign sub_rst_n = sub_q;
  assign rd_cov_start = go_q;
  assign rd_msg_start = go_q;
  assign wr_start = go_q;
  assign rd_cov_size = cov_q;
  assign rd_msg_size = msg_q;
  assign wr_size = cov_q;
endmodule

// File: tb/tb_stego_job_seq.sv
// tb_stego_job_seq: table, hand-written and random jobs checked cycle by cycle against an arithmetic job model
module tb_stego_job_seq;
  localparam int CLR = 2;
  localparam int TO = 100;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [31:0] cover_size = '0, msg_size = '0;
  logic rd_cov_finish = 1'b0, rd_msg_finish = 1'b0, wr_finish = 1'b0;
  logic busy, done, err, irq, sub_rst_n, rd_cov_start, rd_msg_start, wr_start;
  logic [2:0] err_code;
  logic [31:0] rd_cov_size, rd_msg_size, wr_size;
  logic [10:0] outs;
  logic [95:0] sizes;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] cv, ms;
    int f0, f1, f2;
    bit p;
    int ab;
    logic [2:0] xc;
    int xt;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  stego_job_seq #(.REG_WIDTH(32), .CLR_CYCLES(CLR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cover_size(cover_size), .msg_size(msg_size),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .irq(irq),
    .sub_rst_n(sub_rst_n), .rd_cov_start(rd_cov_start), .rd_msg_start(rd_msg_start),
    .wr_start(wr_start), .rd_cov_size(rd_cov_size), .rd_msg_size(rd_msg_size),
    .wr_size(wr_size), .rd_cov_finish(rd_cov_finish), .rd_msg_finish(rd_msg_finish),
    .wr_finish(wr_finish)
  );
  assign outs = {busy, done, err, irq, rd_cov_start, rd_msg_start, wr_start, sub_rst_n, err_code};
  assign sizes = {rd_cov_size, rd_msg_size, wr_size};
  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // finish for RUN cycle f is sampled at edge f+CLR+3 counted from the start edge
  function automatic logic fin(input int f, input int e, input bit p);
    return p ? e == f + CLR + 3 : e >= f + CLR + 3;
  endfunction
  // job outcome: code and the edge (1 = edge sampling start) after which done/err shows
  function automatic void model(input logic [31:0] cv, input logic [31:0] ms, input int f0, input int f1,
                                input int f2, input int ab, output logic [2:0] c, output int t);
    int last;
    last = f0 > f1 ? f0 : f1;
    last = f2 > last ? f2 : last;
    if (cv == 0) begin c = 3'd1; t = 2; end
    else if (longint'(ms) * 8 > longint'(cv)) begin c = 3'd2; t = 2; end
    else if (TO != 0 && last > TO) begin c = 3'd3; t = CLR + 3 + TO; end
    else begin c = 3'd0; t = CLR + 3 + last; end
    if (ab >= 2 && ab <= t) begin c = 3'd4; t = ab; end
  endfunction
  task automatic run_job(input string tag, input vec_t v);
    logic [10:0] x;
    bit fe, go;
    cover_size = v.cv;
    msg_size = v.ms;
    start = 1'b1;
    for (int e = 1; e <= v.xt + 3; e++) begin
      abort = e == v.ab;
      rd_cov_finish = fin(v.f0, e, v.p);
      rd_msg_finish = fin(v.f1, e, v.p);
      wr_finish = fin(v.f2, e, v.p);
      @(posedge clk);
      @(negedge clk);
      fe = e >= v.xt;
      go = e >= CLR + 2 && e < v.xt;
      x = {e < v.xt, fe && v.xc == 0, fe && v.xc != 0, e == v.xt, go, go, go, go || (fe && v.xc == 0),
           fe ? v.xc : 3'd0};
      check($sformatf("%s edge%0d", tag, e), outs, x);
      if (e == v.xt) check({tag, " sizes"}, sizes, {v.cv, v.ms, v.cv});
    end
    start = 1'b0;
    abort = 1'b0;
    rd_cov_finish = 1'b0;
    rd_msg_finish = 1'b0;
    wr_finish = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " back to idle"}, outs, {8'b0, v.xc});
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    vec_t v;
    tbl.push_back('{64, 8, 10, 20, 30, 1, 0, 3'd0, 35});
    tbl.push_back('{64, 8, 30, 10, 20, 0, 0, 3'd0, 35});
    tbl.push_back('{64, 8, 20, 30, 10, 1, 0, 3'd0, 35});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 3'd1, 2});
    tbl.push_back('{63, 8, 1, 1, 1, 1, 0, 3'd2, 2});
    tbl.push_back('{64, 8, 1, 1, 1, 0, 0, 3'd0, 6});
    tbl.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 1, 1, 0, 3'd2, 2});
    tbl.push_back('{32'hFFFF_FFFF, 32'h2000_0000, 1, 1, 1, 1, 0, 3'd2, 2});
    tbl.push_back('{8, 1, 1, 2, 3, 1, 0, 3'd0, 8});
    tbl.push_back('{64, 8, 5, 7, 200, 0, 0, 3'd3, 105});
    tbl.push_back('{64, 8, 100, 3, 4, 1, 0, 3'd0, 105});
    tbl.push_back('{64, 8, 101, 3, 4, 1, 0, 3'd3, 105});
    tbl.push_back('{64, 8, 10, 20, 30, 1, 3, 3'd4, 3});
    tbl.push_back('{64, 8, 10, 20, 30, 1, 20, 3'd4, 20});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 3'd1, 2});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 2, 3'd4, 2});
    tbl.push_back('{64, 8, 30, 30, 30, 1, 35, 3'd4, 35});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outs", outs, '0);
    check("reset sizes", sizes, '0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle without start", outs, '0);
    foreach (tbl[i]) run_job($sformatf("vec%0d", i), tbl[i]);
    cover_size = 64;
    msg_size = 8;
    start = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("mid-run active", {busy, sub_rst_n, rd_cov_start}, 3'b111);
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid-run reset outs", outs, '0);
    check("mid-run reset sizes", sizes, '0);
    rst_n = 1'b1;
    run_job("after reset", '{64, 8, 2, 4, 6, 1, 0, 3'd0, CLR + 3 + 6});
    for (int j = 0; j < 40; j++) begin
      v.cv = $urandom_range(0, 9) == 0 ? 32'd0 : 32'($urandom_range(1, 200));
      v.ms = 32'($urandom_range(0, int'(v.cv) / 8 + 2));
      v.f0 = $urandom_range(1, 30);
      v.f1 = $urandom_range(1, 30);
      v.f2 = $urandom_range(0, 4) == 0 ? $urandom_range(90, 115) : $urandom_range(1, 30);
      v.p = 1'($urandom_range(0, 1));
      v.ab = $urandom_range(0, 3) == 0 ? $urandom_range(1, 60) : 0;
      model(v.cv, v.ms, v.f0, v.f1, v.f2, v.ab, v.xc, v.xt);
      run_job($sformatf("rand%0d", j), v);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
